// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared state encoding, default bus timing and output bundle for the RTC bus controller.
package rtc_bus_pkg;
  localparam int CNT_W = 8;
  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 4;
  localparam int T_HOLD_DEF = 2;
  localparam int T_GAP_DEF = 2;
  typedef enum logic [3:0] {
    IDLE, A_REQ, A_LAT, A_SET, A_STB, A_HLD,
    D_REQ, D_LAT, D_SET, D_STB, D_HLD, GAP, DONE
  } state_e;
  typedef struct packed {
    logic       dir_phase;
    logic       dat_phase;
    logic       phase_done;
    logic       rdata_valid;
    logic       busy;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_sel;
    logic       ad_oe;
    logic [7:0] ad_out;
  } out_t;
  localparam out_t OUT_RST = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, default: '0};
endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// rtc_bus_ctrl_if: sequencer handshake and RTC A/D bus signals of the bus controller.
interface rtc_bus_ctrl_if;
  logic       req_wr;
  logic       req_rd;
  logic [7:0] byte_in;
  logic       dir_phase;
  logic       dat_phase;
  logic       phase_done;
  logic       busy;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;
  logic       ad_sel;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] rdata;
  logic       rdata_valid;
  modport master (
    input  req_wr, req_rd, byte_in, ad_in,
    output dir_phase, dat_phase, phase_done, busy, ad_out, ad_oe,
           ad_sel, cs_n, rd_n, wr_n, rdata, rdata_valid
  );
  modport slave (
    output req_wr, req_rd, byte_in, ad_in,
    input  dir_phase, dat_phase, phase_done, busy, ad_out, ad_oe,
           ad_sel, cs_n, rd_n, wr_n, rdata, rdata_valid
  );
endinterface

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: loadable down-counter that holds at zero and flags it.
module rtc_phase_timer
  import rtc_bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/rtc_bus.sv
// rtc_bus_ctrl: expands a per-byte transfer request into a multiplexed address/data
// cycle on the RTC A/D bus; every output is registered from the next state.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input logic clk,
  input logic reset,
  rtc_bus_ctrl_if.master bus
);
  state_e state_q, state_d;
  logic wr_q, wr_d, armed_q, armed_d, zero, load, a_ph, d_ph, timed;
  logic [7:0] addr_q, addr_d, data_q, data_d, rdata_q;
  logic [CNT_W-1:0] load_val;
  out_t out_q, out_d;
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    armed_d = armed_q;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      IDLE: begin
        armed_d = !(bus.req_wr || bus.req_rd) || (armed_q && !(bus.req_wr || bus.req_rd));
        if ((bus.req_wr || bus.req_rd) && armed_q) begin
          state_d = A_REQ;
          wr_d = bus.req_wr;
        end
      end
      A_REQ: state_d = A_LAT;
      A_LAT: begin
        addr_d = bus.byte_in;
        state_d = A_SET;
      end
      A_SET: state_d = zero ? A_STB : A_SET;
      A_STB: state_d = zero ? A_HLD : A_STB;
      A_HLD: state_d = zero ? D_REQ : A_HLD;
      D_REQ: state_d = D_LAT;
      D_LAT: begin
        data_d = wr_q ? bus.byte_in : data_q;
        state_d = D_SET;
      end
      D_SET: state_d = zero ? D_STB : D_SET;
      D_STB: state_d = zero ? D_HLD : D_STB;
      D_HLD: state_d = zero ? GAP : D_HLD;
      GAP:   state_d = zero ? DONE : GAP;
      default: state_d = IDLE;
    endcase
  end
  assign a_ph  = state_d inside {A_SET, A_STB, A_HLD};
  assign d_ph  = state_d inside {D_SET, D_STB, D_HLD};
  assign timed = a_ph || d_ph || state_d == GAP;
  // Reload only on entry so each timed state lasts exactly its configured count.
  assign load = timed && state_d != state_q;
  assign load_val = state_d inside {A_SET, D_SET} ? CNT_W'(T_SETUP - 1) :
                    state_d inside {A_STB, D_STB} ? CNT_W'(T_PULSE - 1) :
                    state_d inside {A_HLD, D_HLD} ? CNT_W'(T_HOLD - 1) : CNT_W'(T_GAP - 1);
  rtc_phase_timer u_timer (
    .clk(clk), .reset(reset), .load_i(load), .val_i(load_val), .zero_o(zero)
  );
  always_comb begin
    out_d.dir_phase   = state_d == A_REQ;
    out_d.dat_phase   = state_d == D_REQ && wr_d;
    out_d.phase_done  = state_d == DONE;
    out_d.rdata_valid = state_d == DONE && !wr_d;
    out_d.busy        = state_d != IDLE;
    out_d.cs_n        = !(a_ph || d_ph);
    out_d.wr_n        = !(state_d == A_STB || (state_d == D_STB && wr_d));
    out_d.rd_n        = !(state_d == D_STB && !wr_d);
    out_d.ad_sel      = d_ph;
    out_d.ad_oe       = a_ph || (d_ph && wr_d);
    out_d.ad_out      = a_ph ? addr_d : (d_ph && wr_d) ? data_d : 8'h00;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      wr_q <= 1'b0;
      armed_q <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
      out_q <= OUT_RST;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      armed_q <= armed_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rdata_q <= (state_q == D_STB && zero && !wr_q) ? bus.ad_in : rdata_q;
      out_q <= out_d;
    end
  assign bus.dir_phase   = out_q.dir_phase;
  assign bus.dat_phase   = out_q.dat_phase;
  assign bus.phase_done  = out_q.phase_done;
  assign bus.rdata_valid = out_q.rdata_valid;
  assign bus.busy        = out_q.busy;
  assign bus.cs_n        = out_q.cs_n;
  assign bus.rd_n        = out_q.rd_n;
  assign bus.wr_n        = out_q.wr_n;
  assign bus.ad_sel      = out_q.ad_sel;
  assign bus.ad_oe       = out_q.ad_oe;
  assign bus.ad_out      = out_q.ad_out;
  assign bus.rdata       = rdata_q;
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: scoreboard bench; stimulus pushes expected transactions, a monitor checks them at phase_done.
module tb_rtc_bus_ctrl;
  logic clk = 0, reset = 1;
  int cyc = 0, checks = 0, errors = 0, done_cnt = 0;
  int a_w = 0, d_w = 0, dat_cnt = 0;
  logic [7:0] cur_addr = 0, cur_data = 0, rd_val = 8'h37, a_bus, d_bus;
  logic a_oe, d_oe, d_wr;
  typedef struct {
    int         cyc;
    bit         rd;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  rtc_bus_ctrl_if bus ();
  rtc_bus_ctrl_if bus2 ();
  rtc_bus_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master));
  rtc_bus_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #100000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp_v, cyc);
    end
  endtask
  // Upstream sequencer model: byte valid the cycle after each phase pulse; RTC drives ad_in while rd_n is low.
  always @(negedge clk) begin
    if (bus.dir_phase) bus.byte_in = cur_addr;
    if (bus.dat_phase) bus.byte_in = cur_data;
    bus.ad_in = bus.rd_n ? 8'hFF : rd_val;
  end
  always @(negedge clk) begin
    if (reset) begin
      a_w = 0; d_w = 0; dat_cnt = 0;
    end else begin
      if (!bus.rd_n || !bus.wr_n) begin
        chk("strobe_exclusive", 32'(!bus.rd_n && !bus.wr_n), 0);
        chk("strobe_under_cs", 32'(bus.cs_n), 0);
      end
      if (!bus.wr_n && !bus.ad_sel) begin
        a_w++; a_bus = bus.ad_out; a_oe = bus.ad_oe;
      end
      if (bus.ad_sel && (!bus.wr_n || !bus.rd_n)) begin
        d_w++; d_bus = bus.ad_out; d_oe = bus.ad_oe; d_wr = !bus.wr_n;
      end
      if (bus.dat_phase) dat_cnt++;
      if (bus.phase_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_phase_done: got pulse expected none (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("rdata_valid", 32'(bus.rdata_valid), 32'(e.rd));
          if (e.rd) chk("rdata", 32'(bus.rdata), 32'(e.rdata));
          chk("addr_on_bus", 32'(a_bus), 32'(e.addr));
          chk("addr_oe", 32'(a_oe), 1);
          chk("addr_strobe_width", a_w, 4);
          chk("data_strobe_width", d_w, 4);
          chk("data_strobe_is_wr", 32'(d_wr), 32'(!e.rd));
          chk("data_on_bus", 32'(d_bus), e.rd ? 0 : 32'(e.data));
          chk("data_oe", 32'(d_oe), 32'(!e.rd));
          chk("dat_phase_count", dat_cnt, e.rd ? 0 : 1);
        end
        a_w = 0; d_w = 0; dat_cnt = 0;
      end
    end
  end
  task automatic start(bit w, bit r, logic [7:0] a, logic [7:0] d);
    cur_addr = a;
    cur_data = d;
    exp_q.push_back('{cyc + 23, !w, a, d, rd_val});
    bus.req_wr = w;
    bus.req_rd = r;
  endtask
  task automatic wait_done();
    int n = done_cnt;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_cnt > n) break;
    end
    chk("done_seen", 32'(done_cnt > n), 1);
  endtask
  task automatic run_txn(bit w, bit r, logic [7:0] a, logic [7:0] d);
    start(w, r, a, d);
    wait_done();
    bus.req_wr = 0;
    bus.req_rd = 0;
    @(negedge clk);
  endtask
  initial begin
    int n, t0, low, falls, dc;
    logic prev;
    bus.req_wr = 0; bus.req_rd = 0;
    bus2.req_wr = 0; bus2.req_rd = 0; bus2.byte_in = 8'h5A; bus2.ad_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(bus.cs_n), 1);
    chk("rst_rd_n", 32'(bus.rd_n), 1);
    chk("rst_wr_n", 32'(bus.wr_n), 1);
    chk("rst_ad_oe", 32'(bus.ad_oe), 0);
    chk("rst_ad_sel", 32'(bus.ad_sel), 0);
    chk("rst_ad_out", 32'(bus.ad_out), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.phase_done), 0);
    chk("rst_dir", 32'(bus.dir_phase), 0);
    reset = 0;
    @(negedge clk);
    run_txn(1, 0, 8'h21, 8'h45);
    run_txn(0, 1, 8'h22, 8'h00);
    n = done_cnt;
    start(1, 0, 8'h33, 8'h44);
    repeat (60) @(negedge clk);
    chk("rearm_single_txn", done_cnt - n, 1);
    chk("rearm_idle", 32'(bus.busy), 0);
    bus.req_wr = 0;
    @(negedge clk);
    start(1, 0, 8'h55, 8'h66);
    wait_done();
    bus.req_wr = 0;
    @(negedge clk);
    run_txn(1, 1, 8'h77, 8'h88);
    start(1, 0, 8'h99, 8'hAA);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!bus.wr_n && !bus.ad_sel) break;
    end
    chk("reached_a_stb", 32'(!bus.wr_n && !bus.ad_sel), 1);
    reset = 1;
    #1;
    chk("abort_cs_n", 32'(bus.cs_n), 1);
    chk("abort_wr_n", 32'(bus.wr_n), 1);
    chk("abort_ad_oe", 32'(bus.ad_oe), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    exp_q.delete();
    bus.req_wr = 0;
    n = done_cnt;
    @(negedge clk);
    reset = 0;
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt, n);
    run_txn(1, 0, 8'hBC, 8'hDE);
    bus2.req_wr = 1;
    t0 = cyc; low = 0; falls = 0; dc = -1; prev = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus2.wr_n) low++;
      if (prev && !bus2.wr_n) falls++;
      prev = bus2.wr_n;
      if (bus2.phase_done && dc < 0) dc = cyc;
    end
    chk("fast_done_cycle", dc, t0 + 12);
    chk("fast_strobe_cycles", low, 2);
    chk("fast_strobe_count", falls, 2);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
